// File: rtl/reg_write_demux.sv
// reg_write_demux: write-side distribution for a register bank.
// Decodes the write address into one-hot load enables, steers the write
// word into the selected register, exposes all registers on a flat bus,
// and keeps a written-since-clear mask plus a one-cycle write acknowledge.
module reg_write_demux #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic                                   W_EN,
   input  logic [ADDR_WIDTH-1:0]                  W_ADDR,
   input  logic [DATA_WIDTH-1:0]                  W_DATA,
   input  logic                                   CLR,
   output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  REG_BUS,
   output logic [(2**ADDR_WIDTH)-1:0]             W_ONEHOT,
   output logic                                   W_ACK,
   output logic [(2**ADDR_WIDTH)-1:0]             DIRTY
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;

   // Register 0 is excluded from the dirty mask when it is hardwired to zero.
   localparam logic [NUM_REGS-1:0] ZERO_MASK =
      (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b0}}, 1'b1} : '0;

   logic [NUM_REGS-1:0] load_en;
   logic [NUM_REGS-1:0] onehot_reg;
   logic [NUM_REGS-1:0] onehot_next;
   logic [NUM_REGS-1:0] dirty_reg;
   logic [NUM_REGS-1:0] dirty_next;
   logic                ack_reg;

   // Address decoder: exactly one enable when a write is requested, none otherwise.
   always_comb begin
      load_en = '0;
      if (W_EN) begin
         load_en[W_ADDR] = 1'b1;
      end
   end

   // Per-register storage: a 2:1 hold/load mux in front of each flop.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            // Hardwired zero register: writes are silently discarded.
            assign REG_BUS[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else begin : g_data
            logic [DATA_WIDTH-1:0] data_reg;
            logic [DATA_WIDTH-1:0] data_next;

            assign data_next = load_en[gi] ? W_DATA : data_reg;

            // Register load with clear taking priority over any write.
            always_ff @(posedge CLK or negedge RST) begin
               if (!RST) begin
                  data_reg <= '0;
               end else if (CLR) begin
                  data_reg <= '0;
               end else begin
                  data_reg <= data_next;
               end
            end

            assign REG_BUS[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
         end
      end
   endgenerate

   // Next values for the write-tracking state; a zero-register write still
   // updates the one-hot but never marks register 0 dirty.
   always_comb begin
      onehot_next = onehot_reg;
      dirty_next  = dirty_reg | (load_en & ~ZERO_MASK);
      if (W_EN) begin
         onehot_next = load_en;
      end
   end

   // Write-tracking flops: one-hot of last write, dirty mask, acknowledge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         onehot_reg <= '0;
         dirty_reg  <= '0;
         ack_reg    <= 1'b0;
      end else if (CLR) begin
         onehot_reg <= '0;
         dirty_reg  <= '0;
         ack_reg    <= 1'b0;
      end else begin
         onehot_reg <= onehot_next;
         dirty_reg  <= dirty_next;
         ack_reg    <= W_EN;
      end
   end

   assign W_ONEHOT = onehot_reg;
   assign DIRTY    = dirty_reg;
   assign W_ACK    = ack_reg;

endmodule

// File: tb/tb_reg_write_demux.sv
// tb_reg_write_demux: scoreboard bench driving a ZERO_REG=1 and a ZERO_REG=0
// instance from the same stimulus and comparing both against a bench model.
module tb_reg_write_demux;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          clk;
   logic          rst;
   logic          w_en;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          clr;

   logic [NR*DW-1:0] bus_z, bus_n;
   logic [NR-1:0]    onehot_z, onehot_n;
   logic             ack_z, ack_n;
   logic [NR-1:0]    dirty_z, dirty_n;

   reg_write_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
      .CLK(clk), .RST(rst), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
      .CLR(clr), .REG_BUS(bus_z), .W_ONEHOT(onehot_z), .W_ACK(ack_z), .DIRTY(dirty_z)
   );

   reg_write_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_n (
      .CLK(clk), .RST(rst), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
      .CLR(clr), .REG_BUS(bus_n), .W_ONEHOT(onehot_n), .W_ACK(ack_n), .DIRTY(dirty_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             ack;
      logic [NR-1:0]    onehot;
      logic [NR-1:0]    dz;
      logic [NR-1:0]    dn;
      logic [NR*DW-1:0] bz;
      logic [NR*DW-1:0] bn;
   } exp_t;

   exp_t model;
   exp_t sb_q[$];
   int   total;
   int   bad;
   int   ack_cnt;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic compare_all(input exp_t e);
      check_val("ack_z", {63'd0, ack_z}, {63'd0, e.ack});
      check_val("ack_n", {63'd0, ack_n}, {63'd0, e.ack});
      check_val("onehot_z", {32'd0, onehot_z}, {32'd0, e.onehot});
      check_val("onehot_n", {32'd0, onehot_n}, {32'd0, e.onehot});
      check_val("dirty_z", {32'd0, dirty_z}, {32'd0, e.dz});
      check_val("dirty_n", {32'd0, dirty_n}, {32'd0, e.dn});
      for (int k = 0; k < NR; k++) begin
         check_val($sformatf("bus_z[%0d]", k), {32'd0, bus_z[k*DW +: DW]}, {32'd0, e.bz[k*DW +: DW]});
         check_val($sformatf("bus_n[%0d]", k), {32'd0, bus_n[k*DW +: DW]}, {32'd0, e.bn[k*DW +: DW]});
      end
   endtask

   // One transaction: drive inputs, push the model's prediction, clock, pop, compare.
   task automatic drive(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic c);
      exp_t e;
      w_en   = en;
      w_addr = addr;
      w_data = data;
      clr    = c;
      if (c) begin
         model = '0;
      end else if (en) begin
         model.ack    = 1'b1;
         model.onehot = 32'd1 << addr;
         if (addr != 0) begin
            model.bz[addr*DW +: DW] = data;
            model.dz[addr]          = 1'b1;
         end
         model.bn[addr*DW +: DW] = data;
         model.dn[addr]          = 1'b1;
      end else begin
         model.ack = 1'b0;
      end
      sb_q.push_back(model);
      $display("txn en=%0b addr=%0d data=%h clr=%0b", en, addr, data, c);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         compare_all(e);
         if (ack_z) ack_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t zero_e;
      total   = 0;
      bad     = 0;
      ack_cnt = 0;
      model   = '0;
      zero_e  = '0;
      rst     = 1'b0;
      w_en    = 1'b0;
      w_addr  = '0;
      w_data  = '0;
      clr     = 1'b0;

      // Reset state.
      @(posedge clk);
      #1;
      $display("txn reset");
      compare_all(zero_e);
      rst = 1'b1;

      // Idle then single write to register 5, then hold.
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
      check_val("single_slice5", {32'd0, bus_z[191:160]}, {32'd0, 32'hDEADBEEF});
      check_val("single_onehot", {32'd0, onehot_z}, 64'h20);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // Back-to-back sweep over registers 1..31.
      drive(1'b0, 5'd0, 32'h0, 1'b1);
      ack_cnt = 0;
      for (int k = 1; k < NR; k++) begin
         drive(1'b1, AW'(k), k * 32'h01010101, 1'b0);
      end
      check_val("sweep_ack_cycles", 64'(ack_cnt), 64'd31);
      check_val("sweep_dirty", {32'd0, dirty_z}, 64'hFFFFFFFE);
      check_val("sweep_onehot", {32'd0, onehot_z}, 64'h80000000);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // Register 0: discarded on the zero-reg instance, stored on the other.
      drive(1'b0, 5'd0, 32'h0, 1'b1);
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
      check_val("zero_slice_z", {32'd0, bus_z[31:0]}, 64'd0);
      check_val("zero_slice_n", {32'd0, bus_n[31:0]}, 64'hFFFFFFFF);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // CLR versus simultaneous write.
      drive(1'b1, 5'd3, 32'h33333333, 1'b0);
      drive(1'b1, 5'd7, 32'h77777777, 1'b0);
      drive(1'b1, 5'd9, 32'h12345678, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // Overwrite the same register on consecutive cycles.
      ack_cnt = 0;
      drive(1'b1, 5'd12, 32'hAAAA5555, 1'b0);
      drive(1'b1, 5'd12, 32'h0000FFFF, 1'b0);
      check_val("overwrite_ack_cycles", 64'(ack_cnt), 64'd2);
      check_val("overwrite_dirty", {32'd0, dirty_n}, 64'h00001000);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // Reset asserted mid-stream while an ACK is in flight.
      drive(1'b1, 5'd20, 32'hCAFEF00D, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      $display("txn async reset");
      compare_all(zero_e);
      // Write at an edge while reset is held is lost.
      w_en   = 1'b1;
      w_addr = 5'd21;
      w_data = 32'h21212121;
      @(posedge clk);
      #1;
      $display("txn write under reset");
      compare_all(zero_e);
      w_en  = 1'b0;
      rst   = 1'b1;
      model = '0;

      // Random traffic with occasional clears.
      for (int i = 0; i < 20; i++) begin
         drive(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NR-1)),
               32'($urandom), 1'($urandom_range(0, 9) == 0));
      end

      check_val("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_write_demux.md
Name: reg_write_demux

Overview:
- Write-side counterpart of the read-select mux tree. It decodes a 5-bit register address into a one-hot load enable and distributes one 32-bit write word to the selected register of a 32-entry bank.
- All register contents are presented on a flat bus that feeds the 32:1 read muxes of the register file.
- Also tracks which registers have been written since the last clear, and acknowledges each write.

Parameters:
DATA_WIDTH, 32, width of each register and of W_DATA
ADDR_WIDTH, 5, width of W_ADDR; NUM_REGS = 2**ADDR_WIDTH (32)
ZERO_REG, 1, when 1, register 0 is hardwired to zero and writes to it are discarded

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous active-low reset
W_EN  input  1  write request, sampled at CLK rising edge
W_ADDR  input  ADDR_WIDTH  destination register index
W_DATA  input  DATA_WIDTH  write data
CLR  input  1  synchronous clear of all registers and of the dirty mask
REG_BUS  output  NUM_REGS*DATA_WIDTH  register k on bits [k*DATA_WIDTH +: DATA_WIDTH]
W_ONEHOT  output  NUM_REGS  registered one-hot of the last accepted write address
W_ACK  output  1  one-cycle pulse after each accepted write
DIRTY  output  NUM_REGS  bit k set once register k has been written since reset/CLR

Behaviour:
- Interface: one clock, CLK; reset is asynchronous and active-low, named RST.
- Reset (RST=0, asynchronous, independent of CLK):
  - all registers go to 0, so REG_BUS=0;
  - W_ONEHOT=0, W_ACK=0, DIRTY=0.
  - Outputs hold while RST=0.
  - The first rising edge after RST deasserts behaves as a normal cycle.
- Decode: combinational 5-to-32 decode of W_ADDR gated by W_EN produces the load enables. Exactly one enable is active when W_EN=1, none when W_EN=0.
- Write (W_EN=1, CLR=0 at rising edge):
  - register W_ADDR loads W_DATA;
  - new value is visible on REG_BUS after that edge (1-cycle latency);
  - W_ACK=1 for exactly that following cycle;
  - W_ONEHOT = 1<<W_ADDR, held until the next accepted write, CLR or reset;
  - DIRTY[W_ADDR] set.
- Idle (W_EN=0, CLR=0): all state holds and W_ACK=0.
- Back-to-back writes on consecutive cycles are all accepted. W_ACK stays high continuously. Each write is visible one cycle after its edge.
- Same address on consecutive cycles: the last write wins.
- ZERO_REG=1 and W_ADDR=0:
  - data is discarded and register 0 stays 0;
  - W_ACK still pulses and W_ONEHOT[0] is set;
  - DIRTY[0] is not set.
- ZERO_REG=0: register 0 behaves like any other register.
- CLR=1 at rising edge:
  - all registers, DIRTY and W_ONEHOT go to 0, and W_ACK=0 the next cycle;
  - CLR has priority over a simultaneous W_EN, and that write is dropped (no ACK).
- Reset asserted mid-stream: an in-flight W_ACK pulse is cut off immediately and any write at a coincident edge is lost.
- No combinational path from inputs to outputs; all outputs come directly from flops.
- Structure: address decoder, per-register load-enable flops (reusing 2:1 mux cells for hold/load), DIRTY and W_ONEHOT registers, and the W_ACK flop.

Test Plan:
- Reset: drive RST=0 mid-simulation with registers populated -> REG_BUS, DIRTY, W_ONEHOT and W_ACK are 0 immediately, without waiting for a CLK edge.
- Single write: W_EN=1, W_ADDR=5, W_DATA=32'hDEADBEEF for one cycle ->
  - next cycle: REG_BUS[191:160]=32'hDEADBEEF, W_ACK=1, W_ONEHOT=32'h00000020, DIRTY=32'h00000020;
  - following cycle: W_ACK=0 and values hold.
- Back-to-back sweep: write addr k with data k*32'h01010101 for k=1..31 on consecutive cycles ->
  - W_ACK high 31 cycles;
  - every slice matches;
  - DIRTY=32'hFFFFFFFE;
  - W_ONEHOT ends at 32'h80000000.
- Zero register (ZERO_REG=1): write addr 0 with 32'hFFFFFFFF -> REG_BUS[31:0]=0, W_ACK pulses, W_ONEHOT=32'h1, DIRTY[0]=0. Repeat with ZERO_REG=0 -> slice reads 32'hFFFFFFFF and DIRTY[0]=1.
- CLR versus write: populate regs 3 and 7, then assert CLR=1 with W_EN=1, W_ADDR=9, W_DATA=32'h12345678 -> all REG_BUS/DIRTY/W_ONEHOT are 0, W_ACK=0, and register 9 stays 0.
- Overwrite: write addr 12 = 32'hAAAA5555, then addr 12 = 32'h0000FFFF on the next cycle -> slice 12 reads 32'hAAAA5555 then 32'h0000FFFF, W_ACK is high 2 cycles, and DIRTY shows only bit 12.
